// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, instruction field positions and sequencer states shared by the ALU slice.
package alu_pkg;
  localparam logic [5:0] OP_MOVI = 6'h00, OP_MOV = 6'h01, OP_ADD = 6'h04, OP_SUB = 6'h05,
                         OP_AND = 6'h06, OP_MUL = 6'h07, OP_DIV = 6'h08, OP_OR = 6'h09,
                         OP_XOR = 6'h0A, OP_NOT = 6'h0B, OP_SHL = 6'h0C, OP_SHR = 6'h0D,
                         OP_ASR = 6'h0E, OP_CMP = 6'h0F, OP_LRSH = 6'h10;
  localparam int OPC_LSB = 26, RD1_LSB = 21, RS1_LSB = 16, RS2_LSB = 11, RD2_LSB = 6;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB_LO, S_WB_HI} state_e;
  function automatic logic [5:0] f_opc(input logic [31:0] c);
    return c[OPC_LSB +: 6];
  endfunction
  function automatic logic [4:0] f_reg(input logic [31:0] c, input int lsb);
    return c[lsb +: 5];
  endfunction
endpackage

// File: rtl/alu_seq_latency.sv
// alu_seq_latency: combinational opcode decode to execute cycle count, legality and MUL flag.
module alu_seq_latency
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 17
) (
  input  logic [5:0] op,
  output logic [7:0] cycles,
  output logic       legal,
  output logic       is_mul
);
  always_comb begin
    legal = op <= OP_LRSH && op != 6'h02 && op != 6'h03;
    is_mul = op == OP_MUL;
    cycles = is_mul ? 8'(MUL_CYCLES) : op == OP_DIV ? 8'(DIV_CYCLES) : 8'd1;
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: one-instruction-at-a-time READ/EXEC/write-back controller for the 16-bit ALU.
// Define ALU_SEQ_ILLEGAL_TRAP_EN to trap illegal opcodes instead of executing them.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_code,
  output logic [4:0]  rf_raddr_a,
  output logic [4:0]  rf_raddr_b,
  input  logic [15:0] rf_rdata_a,
  input  logic [15:0] rf_rdata_b,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [5:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [15:0] alu_imm,
  input  logic [31:0] alu_result,
  output logic        busy,
  output logic        done,
  output logic        err
);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  state_e      state_q, state_d;
  logic [31:0] code_q, code_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  alu_op_q, alu_op_d;
  logic [15:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, alu_imm_q, alu_imm_d, rf_wdata_q, rf_wdata_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic        rf_we_q, rf_we_d, done_q, done_d, err_q, err_d;
  logic [5:0]  dec_op, cur_op;
  logic [7:0]  cycles;
  logic        legal, is_mul, div0;
  // In IDLE the decoder looks at the incoming word so illegal opcodes can be flagged at acceptance.
  assign cur_op = f_opc(code_q);
  assign dec_op = state_q == S_IDLE ? f_opc(in_code) : cur_op;
  assign div0 = cur_op == OP_DIV && alu_b_q == 16'h0;
  alu_seq_latency #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_lat (
    .op(dec_op), .cycles(cycles), .legal(legal), .is_mul(is_mul)
  );
  always_comb begin
    state_d = state_q;
    code_d = code_q;
    cnt_d = cnt_q;
    alu_op_d = alu_op_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_imm_d = alu_imm_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    rf_we_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      S_IDLE: if (in_valid) begin
        state_d = S_READ;
        code_d = in_code;
        err_d = TRAP_EN && !legal;
      end
      S_READ: if (TRAP_EN && !legal) state_d = S_IDLE;
      else begin
        state_d = S_EXEC;
        cnt_d = 8'd0;
        alu_a_d = rf_rdata_a;
        alu_b_d = rf_rdata_b;
        alu_op_d = cur_op;
        alu_imm_d = code_q[15:0];
      end
      S_EXEC: if (cnt_q == cycles - 8'd1) begin
        state_d = S_WB_LO;
        cnt_d = 8'd0;
        rf_we_d = 1'b1;
        rf_waddr_d = f_reg(code_q, RD1_LSB);
        rf_wdata_d = cur_op == OP_MOVI ? code_q[15:0] : cur_op == OP_MOV ? alu_a_q :
                     div0 ? 16'hFFFF : alu_result[15:0];
        done_d = !is_mul;
        err_d = div0;
      end else cnt_d = cnt_q + 8'd1;
      S_WB_LO: if (is_mul) begin
        state_d = S_WB_HI;
        rf_we_d = 1'b1;
        rf_waddr_d = f_reg(code_q, RD2_LSB);
        rf_wdata_d = alu_result[31:16];
        done_d = 1'b1;
      end else state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      code_q <= '0;
      cnt_q <= '0;
      alu_op_q <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_imm_q <= '0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_we_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q <= code_d;
      cnt_q <= cnt_d;
      alu_op_q <= alu_op_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_imm_q <= alu_imm_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      rf_we_q <= rf_we_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign in_ready = state_q == S_IDLE;
  assign busy = !in_ready;
  assign rf_raddr_a = f_reg(code_q, RS1_LSB);
  assign rf_raddr_b = f_reg(code_q, RS2_LSB);
  assign rf_we = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign alu_op = alu_op_q;
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign alu_imm = alu_imm_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed instructions against a cycle-indexed expectation model of the sequencer.
`timescale 1ns/1ps
module tb_alu_sequencer;
  import alu_pkg::*;
  localparam int MULC = 2, DIVC = 17, DEPTH = 1024;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, load = 1'b1;
  logic [31:0] in_code = '0;
  logic in_ready, rf_we, busy, done, err;
  logic [4:0] rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata, alu_a, alu_b, alu_imm;
  logic [5:0] alu_op;
  logic [31:0] alu_result;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [15:0] rf_mem [32];
  logic [15:0] gold [32];
  bit e_busy [DEPTH], e_we [DEPTH], e_done [DEPTH], e_err [DEPTH], e_ex [DEPTH];
  logic [4:0] e_addr [DEPTH];
  logic [5:0] e_op [DEPTH];
  logic [15:0] e_data [DEPTH], e_a [DEPTH], e_b [DEPTH];
  int acc_c[$], wr_c[$], err_c[$], dn_c[$];
  logic [4:0] wr_a[$];
  logic [15:0] wr_d[$];

  alu_sequencer #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_imm(alu_imm), .alu_result(alu_result), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [15:0] a, b, imm);
    case (op)
      OP_MOVI: return {16'h0, imm};
      OP_MOV:  return {16'h0, a};
      OP_ADD:  return {16'h0, a + b};
      OP_SUB:  return {16'h0, a - b};
      OP_AND:  return {16'h0, a & b};
      OP_MUL:  return 32'(a) * 32'(b);
      OP_DIV:  return b == 16'h0 ? 32'h0 : {16'h0, a / b};
      OP_OR:   return {16'h0, a | b};
      OP_XOR:  return {16'h0, a ^ b};
      OP_NOT:  return {16'h0, ~a};
      OP_SHL:  return {16'h0, a << b[3:0]};
      OP_SHR:  return {16'h0, a >> b[3:0]};
      OP_ASR:  return {16'h0, 16'($signed(a) >>> b[3:0])};
      OP_CMP:  return {31'h0, a < b};
      OP_LRSH: return {a, b} >> b[3:0];
      default: return {b, a} ^ 32'h5A5A_A5A5;
    endcase
  endfunction

  function automatic logic [15:0] init_val(input int i);
    case (i)
      1: return 16'h0005;
      2: return 16'h0003;
      8: return 16'h1234;
      9: return 16'h0100;
      10: return 16'h0000;
      11: return 16'h0064;
      12: return 16'h0007;
      default: return 16'h1000 + 16'(i);
    endcase
  endfunction

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] d1, s1, s2, d2);
    return {op, d1, s1, s2, d2, 6'h0};
  endfunction

  function automatic logic [31:0] enci(input logic [5:0] op, input logic [4:0] d1, input logic [15:0] imm);
    return {op, d1, 5'h0, imm};
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b, alu_imm);
  assign rf_rdata_a = rf_mem[rf_raddr_a];
  assign rf_rdata_b = rf_mem[rf_raddr_b];

  always @(posedge clk) begin
    if (load) for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
    else if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Expected behaviour of one accepted instruction, laid out on the cycle timeline from acceptance t0.
  task automatic model(input int t0);
    logic [5:0] op;
    logic [15:0] a, b, imm;
    logic [31:0] r;
    int n, lo, last;
    op = in_code[31:26];
    imm = in_code[15:0];
    a = gold[in_code[20:16]];
    b = gold[in_code[15:11]];
    acc_c.push_back(t0);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    if (op > 6'h10 || op == 6'h02 || op == 6'h03) begin
      e_busy[t0 + 1] = 1'b1;
      e_err[t0 + 1] = 1'b1;
      return;
    end
`endif
    n = op == OP_MUL ? MULC : op == OP_DIV ? DIVC : 1;
    lo = t0 + 2 + n;
    last = lo + (op == OP_MUL ? 1 : 0);
    for (int t = t0 + 1; t <= last; t++) e_busy[t] = 1'b1;
    for (int t = t0 + 2; t < lo; t++) begin
      e_ex[t] = 1'b1;
      e_a[t] = a;
      e_b[t] = b;
      e_op[t] = op;
    end
    r = alu_fn(op, a, b, imm);
    e_we[lo] = 1'b1;
    e_addr[lo] = in_code[25:21];
    e_data[lo] = op == OP_MOVI ? imm : op == OP_MOV ? a : (op == OP_DIV && b == 16'h0) ? 16'hFFFF : r[15:0];
    e_err[lo] = op == OP_DIV && b == 16'h0;
    e_done[last] = 1'b1;
    if (op == OP_MUL) begin
      e_we[last] = 1'b1;
      e_addr[last] = in_code[10:6];
      e_data[last] = r[31:16];
    end
  endtask

  always @(negedge clk) begin
    if (load) for (int i = 0; i < 32; i++) gold[i] = init_val(i);
    if (!rst_n) begin
      for (int t = cyc; t < DEPTH; t++) begin
        e_busy[t] = 1'b0;
        e_we[t] = 1'b0;
        e_done[t] = 1'b0;
        e_err[t] = 1'b0;
        e_ex[t] = 1'b0;
      end
    end else if (cyc < DEPTH - 32) begin
      chk("in_ready", 32'(in_ready), 32'(!e_busy[cyc]));
      chk("busy", 32'(busy), 32'(e_busy[cyc]));
      chk("rf_we", 32'(rf_we), 32'(e_we[cyc]));
      chk("done", 32'(done), 32'(e_done[cyc]));
      chk("err", 32'(err), 32'(e_err[cyc]));
      if (e_we[cyc]) begin
        chk("rf_waddr", 32'(rf_waddr), 32'(e_addr[cyc]));
        chk("rf_wdata", 32'(rf_wdata), 32'(e_data[cyc]));
        gold[e_addr[cyc]] = e_data[cyc];
      end
      if (e_ex[cyc]) begin
        chk("alu_op", 32'(alu_op), 32'(e_op[cyc]));
        chk("alu_a", 32'(alu_a), 32'(e_a[cyc]));
        chk("alu_b", 32'(alu_b), 32'(e_b[cyc]));
      end
      if (rf_we) begin
        wr_c.push_back(cyc);
        wr_a.push_back(rf_waddr);
        wr_d.push_back(rf_wdata);
      end
      if (err) err_c.push_back(cyc);
      if (done) dn_c.push_back(cyc);
      if (in_valid && !e_busy[cyc]) model(cyc);
    end
  end

  task automatic send(input logic [31:0] code);
    bit ok;
    ok = 1'b0;
    in_code = code;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_code = $urandom;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("idle_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    @(posedge clk);
    #1;
    load = 1'b0;
    rst_n = 1'b1;
    send(enc(OP_ADD, 5'd4, 5'd1, 5'd2, 5'd0));
    wait_idle();
    chk("add_latency", 32'(wr_c[$] - acc_c[$]), 32'd3);
    chk("add_addr", 32'(wr_a[$]), 32'd4);
    chk("add_data", 32'(wr_d[$]), 32'h0008);
    send(enc(OP_MUL, 5'd6, 5'd8, 5'd9, 5'd7));
    wait_idle();
    chk("mul_lo_addr", 32'(wr_a[$-1]), 32'd6);
    chk("mul_lo_data", 32'(wr_d[$-1]), 32'h3400);
    chk("mul_hi_addr", 32'(wr_a[$]), 32'd7);
    chk("mul_hi_data", 32'(wr_d[$]), 32'h0012);
    chk("mul_latency", 32'(wr_c[$] - acc_c[$]), 32'd5);
    chk("mul_done_on_hi", 32'(dn_c[$]), 32'(wr_c[$]));
    send(enc(OP_DIV, 5'd5, 5'd11, 5'd10, 5'd0));
    wait_idle();
    chk("div0_data", 32'(wr_d[$]), 32'hFFFF);
    chk("div0_latency", 32'(wr_c[$] - acc_c[$]), 32'd19);
    chk("div0_err_with_we", 32'(err_c[$]), 32'(wr_c[$]));
    send(enc(OP_DIV, 5'd13, 5'd11, 5'd12, 5'd0));
    wait_idle();
    chk("div_data", 32'(wr_d[$]), 32'h000E);
    nw = wr_c.size();
    send(enc(6'h3F, 5'd14, 5'd1, 5'd2, 5'd0));
    wait_idle();
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    chk("trap_err_latency", 32'(err_c[$] - acc_c[$]), 32'd1);
    chk("trap_no_write", 32'(wr_c.size()), 32'(nw));
`else
    chk("illegal_latency", 32'(wr_c[$] - acc_c[$]), 32'd3);
    chk("illegal_addr", 32'(wr_a[$]), 32'd14);
    chk("illegal_data", 32'(wr_d[$]), 32'hA5A0);
`endif
    nw = wr_c.size();
    send(enc(OP_DIV, 5'd15, 5'd11, 5'd12, 5'd0));
    repeat (4) @(posedge clk);
    #1;
    chk("busy_before_reset", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_rf_we", 32'(rf_we), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("no_write_after_reset", 32'(wr_c.size()), 32'(nw));
    chk("r15_untouched", 32'(rf_mem[15]), 32'h100F);
    send(enc(OP_ADD, 5'd16, 5'd1, 5'd2, 5'd0));
    wait_idle();
    chk("add2_latency", 32'(wr_c[$] - acc_c[$]), 32'd3);
    chk("add2_data", 32'(rf_mem[16]), 32'h0008);
    send(enc(OP_MUL, 5'd17, 5'd8, 5'd9, 5'd17));
    wait_idle();
    chk("mul_same_dst_lo", 32'(wr_d[$-1]), 32'h3400);
    chk("mul_same_dst_final", 32'(rf_mem[17]), 32'h0012);
    send(enci(OP_MOVI, 5'd1, 16'hBEEF));
    send(enci(OP_MOVI, 5'd2, 16'h0001));
    wait_idle();
    chk("movi_b2b_gap", 32'(acc_c[$] - acc_c[$-1]), 32'd4);
    chk("movi1_wb", 32'(wr_c[$-1] - acc_c[$-1]), 32'd3);
    chk("movi2_wb", 32'(wr_c[$] - acc_c[$-1]), 32'd7);
    chk("movi1_data", 32'(rf_mem[1]), 32'hBEEF);
    chk("movi2_data", 32'(rf_mem[2]), 32'h0001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
